// File: rtl/vga_timing_800x600.sv
// vga_timing_800x600: 800x600@60 raster counters with registered, coherent sync/video decode
module vga_timing_800x600 #(
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [10:0] hc,
    output logic [10:0] vc,
    output logic        hsync,
    output logic        vsync,
    output logic        vidon,
    output logic        frame_start
);
    localparam logic [10:0] H_LAST = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [10:0] V_LAST = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [10:0] H_SW   = 11'(H_SYNC);
    localparam logic [10:0] V_SW   = 11'(V_SYNC);
    localparam logic [10:0] H_VS   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_VE   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_VS   = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_VE   = 11'(V_SYNC + V_BP + V_ACTIVE);

    logic [10:0] hc_nx, vc_nx;
    logic        h_wrap, v_wrap;

    // next raster position; flags below decode this so nothing lags the counters
    always_comb begin
        h_wrap = hc == H_LAST;
        v_wrap = vc == V_LAST;
        hc_nx  = pix_en ? (h_wrap ? 11'd0 : hc + 11'd1) : hc;
        vc_nx  = (pix_en && h_wrap) ? (v_wrap ? 11'd0 : vc + 11'd1) : vc;
    end

    // counters and decoded outputs all registered from the same next position
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc          <= 11'd0;
            vc          <= 11'd0;
            hsync       <= H_POL;
            vsync       <= V_POL;
            vidon       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hc          <= hc_nx;
            vc          <= vc_nx;
            hsync       <= (hc_nx < H_SW) ? H_POL : ~H_POL;
            vsync       <= (vc_nx < V_SW) ? V_POL : ~V_POL;
            vidon       <= (hc_nx >= H_VS) && (hc_nx < H_VE) && (vc_nx >= V_VS) && (vc_nx < V_VE);
            frame_start <= pix_en && h_wrap && v_wrap;
        end
    end
endmodule

// File: tb/tb_vga_timing_800x600.sv
// tb_vga_timing_800x600: directed checks on a default-size and a reduced-size raster
module tb_vga_timing_800x600;
    logic        clk = 1'b0;
    logic        rst_d, rst_s, en_d, en_s;
    logic [10:0] hc_d, vc_d, hc_s, vc_s;
    logic        hs_d, vs_d, vid_d, fs_d;
    logic        hs_s, vs_s, vid_s, fs_s;
    int          checks = 0;
    int          failures = 0;

    // reduced raster: H 8+4+20+4=36, V 2+3+10+1=16, frame 576, hsync active-low
    localparam int SH = 36;
    localparam int SF = 576;

    always #5 clk = ~clk;

    vga_timing_800x600 dut (
        .clk(clk), .rst_n(rst_d), .pix_en(en_d),
        .hc(hc_d), .vc(vc_d), .hsync(hs_d), .vsync(vs_d), .vidon(vid_d), .frame_start(fs_d)
    );

    vga_timing_800x600 #(
        .H_SYNC(8), .H_BP(4), .H_ACTIVE(20), .H_FP(4),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(10), .V_FP(1),
        .H_POL(1'b0), .V_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_s), .pix_en(en_s),
        .hc(hc_s), .vc(vc_s), .hsync(hs_s), .vsync(vs_s), .vidon(vid_s), .frame_start(fs_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_d = 1'b0; rst_s = 1'b0; en_d = 1'b1; en_s = 1'b1;
        repeat (3) step();
        checks++;
        if (hc_d !== 11'd0 || vc_d !== 11'd0) begin
            failures++; $display("FAIL reset_pos got (%0d,%0d) want (0,0)", hc_d, vc_d);
        end
        checks++;
        if ({hs_d, vs_d, vid_d, fs_d} !== 4'b1100) begin
            failures++; $display("FAIL reset_flags got hs/vs/vid/fs=%b want 1100", {hs_d, vs_d, vid_d, fs_d});
        end
        checks++;
        if ({hs_s, vs_s, vid_s, fs_s} !== 4'b0100) begin
            failures++; $display("FAIL reset_flags_pol got hs/vs/vid/fs=%b want 0100", {hs_s, vs_s, vid_s, fs_s});
        end
        rst_d = 1'b1;
        step();
        checks++;
        if (hc_d !== 11'd1 || vc_d !== 11'd0 || fs_d !== 1'b0) begin
            failures++; $display("FAIL release_first got hc=%0d vc=%0d fs=%b want hc=1 vc=0 fs=0", hc_d, vc_d, fs_d);
        end
    endtask

    task automatic test_hline();
        int n = 0;
        while (!(hc_d == 11'd1055 && vc_d == 11'd29) && n < 40000) begin
            step(); n++;
        end
        checks++;
        if (n >= 40000) begin
            failures++; $display("FAIL hline_reach got (%0d,%0d) want (1055,29) within budget", hc_d, vc_d);
            return;
        end
        for (int i = 0; i < 1056; i++) begin
            step();
            checks++;
            if (hc_d !== 11'(i) || vc_d !== 11'd30) begin
                failures++; $display("FAIL hline_pos got (%0d,%0d) want (%0d,30)", hc_d, vc_d, i);
            end
            checks++;
            if (hs_d !== (i < 128) || vid_d !== (i >= 216 && i < 1016) || vs_d !== 1'b0 || fs_d !== 1'b0) begin
                failures++;
                $display("FAIL hline_flags hc=%0d got hs/vid/vs/fs=%b%b%b%b want %b%b00",
                         i, hs_d, vid_d, vs_d, fs_d, i < 128, i >= 216 && i < 1016);
            end
        end
        step();
        checks++;
        if (hc_d !== 11'd0 || vc_d !== 11'd31 || hs_d !== 1'b1 || vid_d !== 1'b0) begin
            failures++; $display("FAIL hline_wrap got (%0d,%0d) hs=%b vid=%b want (0,31) hs=1 vid=0", hc_d, vc_d, hs_d, vid_d);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while (hc_d != 11'd500 && n < 2000) begin
            step(); n++;
        end
        checks++;
        if (n >= 2000 || vid_d !== 1'b1) begin
            failures++; $display("FAIL mid_reach got hc=%0d vid=%b want hc=500 vid=1", hc_d, vid_d);
        end
        rst_d = 1'b0; en_d = 1'b0;
        step();
        checks++;
        if (hc_d !== 11'd0 || vc_d !== 11'd0 || {hs_d, vs_d, vid_d, fs_d} !== 4'b1100) begin
            failures++;
            $display("FAIL mid_reset got (%0d,%0d) hs/vs/vid/fs=%b want (0,0) 1100", hc_d, vc_d, {hs_d, vs_d, vid_d, fs_d});
        end
        rst_d = 1'b1; en_d = 1'b1;
        step();
        checks++;
        if (hc_d !== 11'd1 || vc_d !== 11'd0) begin
            failures++; $display("FAIL mid_restart got (%0d,%0d) want (1,0)", hc_d, vc_d);
        end
        repeat (215) step();
        checks++;
        if (hc_d !== 11'd216 || vc_d !== 11'd0 || {hs_d, vs_d, vid_d} !== 3'b010) begin
            failures++;
            $display("FAIL mid_count got (%0d,%0d) hs/vs/vid=%b want (216,0) 010", hc_d, vc_d, {hs_d, vs_d, vid_d});
        end
    endtask

    task automatic test_frame();
        int p = 0;
        int vid_cnt = 0;
        int fs_cnt = 0;
        int eh, ev;
        en_s = 1'b1; rst_s = 1'b0;
        step();
        rst_s = 1'b1;
        for (int k = 1; k <= 2 * SF + 1; k++) begin
            step();
            p = (p + 1) % SF;
            eh = p % SH; ev = p / SH;
            if (k <= SF) vid_cnt += int'(vid_s);
            fs_cnt += int'(fs_s);
            checks++;
            if (hc_s !== 11'(eh) || vc_s !== 11'(ev)) begin
                failures++; $display("FAIL frame_pos got (%0d,%0d) want (%0d,%0d)", hc_s, vc_s, eh, ev);
            end
            checks++;
            if (hs_s !== (eh >= 8) || vs_s !== (ev < 2) || vid_s !== (eh >= 12 && eh < 32 && ev >= 5 && ev < 15)
                || fs_s !== (p == 0)) begin
                failures++;
                $display("FAIL frame_flags at (%0d,%0d) got hs/vs/vid/fs=%b%b%b%b want %b%b%b%b", eh, ev,
                         hs_s, vs_s, vid_s, fs_s, eh >= 8, ev < 2, eh >= 12 && eh < 32 && ev >= 5 && ev < 15, p == 0);
            end
        end
        checks++;
        if (vid_cnt != 200) begin
            failures++; $display("FAIL frame_vidon_count got %0d want 200", vid_cnt);
        end
        checks++;
        if (fs_cnt != 2) begin
            failures++; $display("FAIL frame_start_count got %0d want 2", fs_cnt);
        end
    endtask

    task automatic test_pix_en();
        int p = 0;
        int first = -1;
        int second = -1;
        logic en;
        en_s = 1'b1; rst_s = 1'b0;
        step();
        rst_s = 1'b1;
        for (int k = 1; k <= 2 * 3 * SF + 6; k++) begin
            en = (k % 3 == 0);
            en_s = en;
            step();
            if (en) p = (p + 1) % SF;
            if (fs_s === 1'b1) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            checks++;
            if (hc_s !== 11'(p % SH) || vc_s !== 11'(p / SH) || fs_s !== (en && p == 0)) begin
                failures++;
                $display("FAIL pix_en_track clk=%0d got (%0d,%0d) fs=%b want (%0d,%0d) fs=%b",
                         k, hc_s, vc_s, fs_s, p % SH, p / SH, en && p == 0);
            end
        end
        checks++;
        if (first < 0 || second - first != 3 * SF) begin
            failures++; $display("FAIL pix_en_period got %0d want %0d", second - first, 3 * SF);
        end
        en_s = 1'b1;
    endtask

    initial begin
        test_reset();
        test_hline();
        test_mid_reset();
        test_frame();
        test_pix_en();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
